// File: rtl/sprite_blitter.sv
// Sprite blitter: copies a rectangular sprite from a synchronous ROM into the frame buffer,
// skipping transparent pixels and clipping to the screen. Optional BLIT_MIRROR_EN adds row mirroring.
module sprite_blitter #(
    parameter int unsigned SCREEN_W    = 640,
    parameter int unsigned SCREEN_H    = 480,
    parameter logic [4:0]  TRANSPARENT = 5'h15,
    parameter int unsigned FB_AW       = 19,
    parameter int unsigned ROM_AW      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic [6:0]        sprite_w,
    input  logic [6:0]        sprite_h,
    input  logic [ROM_AW-1:0] rom_base,
`ifdef BLIT_MIRROR_EN
    input  logic              mirror,
`endif
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [4:0]        rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [4:0]        fb_pixel
);

    localparam int unsigned COORD_W = 10;
    localparam int unsigned SIZE_W  = 7;
    localparam int unsigned SUM_W   = 11;
    localparam int unsigned PIX_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [COORD_W-1:0] xReg, yReg;
    logic [SIZE_W-1:0]  wReg, hReg;
    logic               mirrorReg;
    logic               mirrorStart;
    logic [SIZE_W-1:0]  col, row;
    logic [ROM_AW-1:0]  rowRomBase;
    logic [FB_AW-1:0]   rowFbBase;

    logic               tagValid;
    logic               tagInBounds;
    logic [FB_AW-1:0]   tagAddr;
    logic [FB_AW-1:0]   heldAddr;
    logic [PIX_W-1:0]   heldPixel;

    logic               lastCol, lastRow;
    logic [ROM_AW-1:0]  nextRowRom;
    logic [ROM_AW-1:0]  rowOffset;
    logic [ROM_AW-1:0]  startOffset;

`ifdef BLIT_MIRROR_EN
    assign mirrorStart = mirror;
`else
    assign mirrorStart = 1'b0;
`endif

    assign lastCol     = (col == wReg - SIZE_W'(1));
    assign lastRow     = (row == hReg - SIZE_W'(1));
    assign nextRowRom  = rowRomBase + ROM_AW'(wReg);
    // Mirrored rows start at the rightmost pixel and walk downwards
    assign rowOffset   = mirrorReg ? (ROM_AW'(wReg) - ROM_AW'(1)) : '0;
    assign startOffset = mirrorStart ? (ROM_AW'(sprite_w) - ROM_AW'(1)) : '0;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = (sprite_w == '0 || sprite_h == '0) ? DONE : RUN;
            RUN:     if (lastCol && lastRow) stateNext = DRAIN;
            DRAIN:   stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Status flags registered from the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (stateNext == RUN) || (stateNext == DRAIN);
            done <= (stateNext == DONE);
        end
    end

    // Address generation: row bases advance by w (ROM) and SCREEN_W (frame), no multiplier in the loop
    always_ff @(posedge Clk) begin
        if (Reset) begin
            xReg       <= '0;
            yReg       <= '0;
            wReg       <= '0;
            hReg       <= '0;
            mirrorReg  <= 1'b0;
            col        <= '0;
            row        <= '0;
            rowRomBase <= '0;
            rowFbBase  <= '0;
            rom_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xReg       <= sprite_x;
                        yReg       <= sprite_y;
                        wReg       <= sprite_w;
                        hReg       <= sprite_h;
                        mirrorReg  <= mirrorStart;
                        col        <= '0;
                        row        <= '0;
                        rowRomBase <= rom_base;
                        rowFbBase  <= FB_AW'(sprite_x) + FB_AW'(sprite_y) * FB_AW'(SCREEN_W);
                        rom_addr   <= rom_base + startOffset;
                    end
                end
                RUN: begin
                    if (lastCol) begin
                        col        <= '0;
                        row        <= row + SIZE_W'(1);
                        rowRomBase <= nextRowRom;
                        rowFbBase  <= rowFbBase + FB_AW'(SCREEN_W);
                        rom_addr   <= nextRowRom + rowOffset;
                    end else begin
                        col      <= col + SIZE_W'(1);
                        rom_addr <= mirrorReg ? (rom_addr - ROM_AW'(1)) : (rom_addr + ROM_AW'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag stage: pixel coordinates delayed one cycle to line up with rom_data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tagValid    <= 1'b0;
            tagInBounds <= 1'b0;
            tagAddr     <= '0;
        end else begin
            tagValid    <= (state == RUN);
            tagInBounds <= (SUM_W'(xReg) + SUM_W'(col) < SUM_W'(SCREEN_W)) &&
                           (SUM_W'(yReg) + SUM_W'(row) < SUM_W'(SCREEN_H));
            tagAddr     <= rowFbBase + FB_AW'(col);
        end
    end

    assign fb_we    = tagValid && tagInBounds && (rom_data != TRANSPARENT);
    assign fb_addr  = fb_we ? tagAddr  : heldAddr;
    assign fb_pixel = fb_we ? rom_data : heldPixel;

    // Address and pixel hold their last written value between writes
    always_ff @(posedge Clk) begin
        if (Reset) begin
            heldAddr  <= '0;
            heldPixel <= '0;
        end else if (fb_we) begin
            heldAddr  <= tagAddr;
            heldPixel <= rom_data;
        end
    end

endmodule
